// File: rtl/conv3x3_stream_filter.sv
// Streaming 3x3 convolution over raster pixels with programmable signed
// coefficient banks, per-frame bank/bypass latching and saturating output.
module conv3x3_stream_filter #(
    parameter int BITWIDTH   = 8,
    parameter int COEF_W     = 8,
    parameter int COLS       = 640,
    parameter int ROWS       = 480,
    parameter int NUM_BANKS  = 4,
    parameter int NORM_SHIFT = 8,
    localparam int BKW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int XW  = $clog2(COLS) + 1,
    localparam int YW  = $clog2(ROWS) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_in_valid,
    input  logic [BITWIDTH-1:0] data_in,
    input  logic [BKW-1:0]      bank_sel,
    input  logic                bypass,
    input  logic                coef_we,
    input  logic [BKW-1:0]      coef_bank,
    input  logic [3:0]          coef_idx,
    input  logic [COEF_W-1:0]   coef_data,
    output logic                data_out_valid,
    output logic [BITWIDTH-1:0] data_out,
    output logic [XW-1:0]       x,
    output logic [YW-1:0]       y,
    output logic                busy,
    output logic                frame_done
);
    localparam int CIW = $clog2(COLS);
    localparam int PW  = BITWIDTH + COEF_W + 1;
    localparam int SW  = BITWIDTH + COEF_W + 5;
    localparam logic [XW-1:0] COL_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(ROWS - 1);
    localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << BITWIDTH) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                     state;
    logic [1:0]                 drain_cnt;
    logic [XW-1:0]              col;
    logic [YW-1:0]              row;
    logic [BKW-1:0]             bank;
    logic                       byp;
    logic signed [COEF_W-1:0]   coef [NUM_BANKS][9];
    logic [BITWIDTH-1:0]        lb0 [COLS];
    logic [BITWIDTH-1:0]        lb1 [COLS];
    logic [BITWIDTH-1:0]        win [9];
    logic                       win_valid;
    logic [XW-1:0]              win_x;
    logic [YW-1:0]              win_y;
    logic                       s1_valid;
    logic signed [PW-1:0]       prod [9];
    logic [BITWIDTH-1:0]        s1_ctr;
    logic [XW-1:0]              s1_x;
    logic [YW-1:0]              s1_y;
    logic                       s2_valid;
    logic signed [SW-1:0]       s2_sum;
    logic [BITWIDTH-1:0]        s2_ctr;
    logic [XW-1:0]              s2_x;
    logic [YW-1:0]              s2_y;
    logic signed [SW-1:0]       tree;
    logic signed [SW-1:0]       shifted;
    logic [BITWIDTH-1:0]        result;
    logic                       accept;
    logic                       coef_ok;
    logic [BKW-1:0]             act_bank;
    logic [CIW-1:0]             ci;

    function automatic logic signed [COEF_W-1:0] gauss(input int t);
        if (t == 4) return COEF_W'(64);
        else if (t % 2 == 1) return COEF_W'(32);
        else return COEF_W'(16);
    endfunction

    assign accept   = data_in_valid && (state != DRAIN);
    assign coef_ok  = coef_we && (coef_idx <= 4'd8) && (32'(coef_bank) < NUM_BANKS);
    assign act_bank = (32'(bank) < NUM_BANKS) ? bank : '0;
    assign ci       = col[CIW-1:0];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            drain_cnt      <= 2'd0;
            col            <= '0;
            row            <= '0;
            bank           <= '0;
            byp            <= 1'b0;
            win_valid      <= 1'b0;
            s1_valid       <= 1'b0;
            s2_valid       <= 1'b0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
            x              <= '0;
            y              <= '0;
            frame_done     <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++)
                for (int t = 0; t < 9; t++)
                    coef[b][t] <= gauss(t);
        end else begin
            frame_done <= 1'b0;
            win_valid  <= 1'b0;
            if (coef_ok)
                coef[coef_bank][coef_idx] <= coef_data;
            unique case (state)
                IDLE: if (accept) begin
                    state <= RUN;
                    bank  <= bank_sel;
                    byp   <= bypass;
                end
                RUN: if (accept && col == COL_LAST && row == ROW_LAST) begin
                    state     <= DRAIN;
                    drain_cnt <= 2'd0;
                end
                DRAIN: if (drain_cnt == 2'd2) begin
                    state      <= IDLE;
                    frame_done <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt + 2'd1;
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                win_valid <= (col >= XW'(2)) && (row >= YW'(2));
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + YW'(1);
                end else begin
                    col <= col + XW'(1);
                end
            end
            s1_valid       <= win_valid;
            s2_valid       <= s1_valid;
            data_out_valid <= s2_valid;
            if (s2_valid) begin
                data_out <= result;
                x        <= s2_x;
                y        <= s2_y;
            end
        end
    end

    // Line buffers and window hold no reset; a window is only flagged once
    // every tap has been rewritten by the current frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[ci] <= data_in;
            lb1[ci] <= lb0[ci];
            win[0]  <= win[1];
            win[1]  <= win[2];
            win[2]  <= lb1[ci];
            win[3]  <= win[4];
            win[4]  <= win[5];
            win[5]  <= lb0[ci];
            win[6]  <= win[7];
            win[7]  <= win[8];
            win[8]  <= data_in;
            win_x   <= col - XW'(1);
            win_y   <= row - YW'(1);
        end
        if (win_valid) begin
            for (int t = 0; t < 9; t++)
                prod[t] <= PW'($signed({1'b0, win[t]})) * PW'(coef[act_bank][t]);
            s1_ctr <= win[4];
            s1_x   <= win_x;
            s1_y   <= win_y;
        end
        if (s1_valid) begin
            s2_sum <= tree;
            s2_ctr <= s1_ctr;
            s2_x   <= s1_x;
            s2_y   <= s1_y;
        end
    end

    always_comb begin
        tree = '0;
        for (int t = 0; t < 9; t++)
            tree = tree + SW'(prod[t]);
    end

    always_comb begin
        shifted = s2_sum >>> NORM_SHIFT;
        if (byp)
            result = s2_ctr;
        else if (shifted[SW-1])
            result = '0;
        else if (shifted > PIX_MAX)
            result = '1;
        else
            result = shifted[BITWIDTH-1:0];
    end

endmodule

// File: tb/tb_conv3x3_stream_filter.sv
// Scoreboard bench for conv3x3_stream_filter: two instances (shift 8 and
// shift 0) share stimulus; expected pixels come from a reference window model.
module tb_conv3x3_stream_filter;
    localparam int BW   = 8;
    localparam int CW   = 8;
    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int NB   = 4;
    localparam int NPIX = COLS * ROWS;
    localparam int NOUT = (COLS - 2) * (ROWS - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          data_in_valid = 1'b0;
    logic [BW-1:0] data_in = '0;
    logic [1:0]    bank_sel = 2'd0;
    logic          bypass = 1'b0;
    logic          coef_we = 1'b0;
    logic [1:0]    coef_bank = 2'd0;
    logic [3:0]    coef_idx = 4'd0;
    logic [CW-1:0] coef_data = '0;

    logic          va, vb, busya, busyb, fda, fdb;
    logic [BW-1:0] da, db;
    logic [3:0]    xa, xb, ya, yb;

    always #5 clk = ~clk;

    conv3x3_stream_filter #(.BITWIDTH(BW), .COEF_W(CW), .COLS(COLS),
        .ROWS(ROWS), .NUM_BANKS(NB), .NORM_SHIFT(8)) dut_a (
        .clk(clk), .rst(rst), .data_in_valid(data_in_valid),
        .data_in(data_in), .bank_sel(bank_sel), .bypass(bypass),
        .coef_we(coef_we), .coef_bank(coef_bank), .coef_idx(coef_idx),
        .coef_data(coef_data), .data_out_valid(va), .data_out(da),
        .x(xa), .y(ya), .busy(busya), .frame_done(fda));

    conv3x3_stream_filter #(.BITWIDTH(BW), .COEF_W(CW), .COLS(COLS),
        .ROWS(ROWS), .NUM_BANKS(NB), .NORM_SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .data_in_valid(data_in_valid),
        .data_in(data_in), .bank_sel(bank_sel), .bypass(bypass),
        .coef_we(coef_we), .coef_bank(coef_bank), .coef_idx(coef_idx),
        .coef_data(coef_data), .data_out_valid(vb), .data_out(db),
        .x(xb), .y(yb), .busy(busyb), .frame_done(fdb));

    typedef struct {
        int x;
        int y;
        int va;
        int vb;
        int acc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cm [NB][9];
    int   img [ROWS][COLS];
    int   mbank;
    bit   mbyp;

    function automatic int pix(input int kind, input int c, input int r);
        case (kind)
            0: return 100;
            1: return (c == 3 && r == 3) ? 200 : 50;
            2: return 255;
            3: return (c * 17 + r * 29) % 256;
            default: return (c * 31 + r * 7 + 5) % 256;
        endcase
    endfunction

    // Expected output for the window completed by accepting pixel (c,r).
    function automatic int model_out(input int c, input int r, input int sh);
        int s;
        if (mbyp) return img[r-1][c-1];
        s = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                s += img[r-2+dr][c-2+dc] * cm[mbank][dr*3+dc];
        s = s >>> sh;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic reset_model();
        for (int b = 0; b < NB; b++)
            for (int t = 0; t < 9; t++)
                cm[b][t] = (t == 4) ? 64 : ((t % 2 == 1) ? 32 : 16);
    endtask

    task automatic write_coef(input int b, input int i, input int v);
        coef_we   = 1'b1;
        coef_bank = 2'(b);
        coef_idx  = 4'(i);
        coef_data = CW'(v);
        @(posedge clk); #1;
        coef_we = 1'b0;
        if (i <= 8 && b < NB) cm[b][i] = v;
    endtask

    task automatic load_bank(input int b, input int taps[9]);
        for (int t = 0; t < 9; t++) write_coef(b, t, taps[t]);
    endtask

    task automatic run_frame(input int kind, input bit gaps, input bit toggle,
                             input int abort_idx);
        int   idx = 0, tail = 0, edge_n = 0;
        int   first_acc = -1, last_acc = -1, nout = 0, nfd = 0, c, r;
        bit   toggled = 0;
        logic [BW-1:0] prev_da = '0;
        exp_t e;
        while (idx < NPIX || tail < 6) begin
            data_in_valid = 1'b0;
            data_in = BW'(idx * 13 + 7);
            if (idx < NPIX) begin
                if (!gaps || $urandom_range(1, 0) == 1) begin
                    c = idx % COLS;
                    r = idx / COLS;
                    img[r][c] = pix(kind, c, r);
                    data_in_valid = 1'b1;
                    data_in = BW'(img[r][c]);
                    if (idx == 0) begin
                        mbank = int'(bank_sel);
                        mbyp = bypass;
                        first_acc = edge_n + 1;
                    end
                    if (idx == abort_idx) rst = 1'b0;
                    else if (c >= 2 && r >= 2)
                        sbq.push_back('{c - 1, r - 1, model_out(c, r, 8),
                                        model_out(c, r, 0), edge_n + 1});
                    if (idx == NPIX - 1) last_acc = edge_n + 1;
                    idx++;
                end
                if (toggle && !toggled && idx == NPIX / 2) begin
                    bank_sel = ~bank_sel;
                    bypass = ~bypass;
                    toggled = 1;
                end
            end else begin
                // beats offered while draining must be dropped
                data_in_valid = (tail < 3);
                tail++;
            end
            @(posedge clk); #1;
            edge_n++;
            if (rst == 1'b0) begin
                rst = 1'b1;
                data_in_valid = 1'b0;
                total++;
                if ({va, vb, fda, fdb, busya, busyb} !== 6'b0)
                    $display("FAIL abort_flags got=%b want=000000",
                             {va, vb, fda, fdb, busya, busyb});
                total++;
                if ({da, xa, ya} !== '0)
                    $display("FAIL abort_outputs got d=%0d x=%0d y=%0d want 0",
                             da, xa, ya);
                if ({da, xa, ya} !== '0 || {va, vb, fda, fdb, busya, busyb} !== 6'b0)
                    bad += ({da, xa, ya} !== '0) + ({va, vb, fda, fdb, busya, busyb} !== 6'b0);
                sbq.delete();
                reset_model();
                for (int k = 0; k < 8; k++) begin
                    @(posedge clk); #1;
                    total++;
                    if ({va, vb, fda, fdb} !== 4'b0) begin
                        bad++;
                        $display("FAIL abort_quiet got=%b want=0000", {va, vb, fda, fdb});
                    end
                end
                return;
            end
            if (edge_n == first_acc) begin
                total++;
                if (busya !== 1'b1 || busyb !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_start got=%b%b want=11", busya, busyb);
                end
            end
            if (va !== vb) begin
                total++;
                bad++;
                $display("FAIL valid_pair got a=%b b=%b", va, vb);
            end
            if (va === 1'b1) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_output x=%0d y=%0d want none", xa, ya);
                end else begin
                    e = sbq.pop_front();
                    nout++;
                    total++;
                    if (xa !== 4'(e.x) || ya !== 4'(e.y)) begin
                        bad++;
                        $display("FAIL coord got=(%0d,%0d) want=(%0d,%0d)",
                                 xa, ya, e.x, e.y);
                    end
                    total++;
                    if (da !== BW'(e.va)) begin
                        bad++;
                        $display("FAIL data_shift8 at (%0d,%0d) got=%0d want=%0d",
                                 e.x, e.y, da, e.va);
                    end
                    total++;
                    if (db !== BW'(e.vb)) begin
                        bad++;
                        $display("FAIL data_shift0 at (%0d,%0d) got=%0d want=%0d",
                                 e.x, e.y, db, e.vb);
                    end
                    total++;
                    if (edge_n !== e.acc + 3) begin
                        bad++;
                        $display("FAIL latency got=%0d want=%0d", edge_n - e.acc, 3);
                    end
                end
                prev_da = da;
            end else if (nout > 0) begin
                total++;
                if (da !== prev_da) begin
                    bad++;
                    $display("FAIL hold got=%0d want=%0d", da, prev_da);
                end
            end
            if (fda === 1'b1) begin
                nfd++;
                total++;
                if (edge_n !== last_acc + 3) begin
                    bad++;
                    $display("FAIL frame_done_time got=%0d want=%0d", edge_n, last_acc + 3);
                end
            end
            total++;
            if (fdb !== fda) begin
                bad++;
                $display("FAIL frame_done_pair got a=%b b=%b", fda, fdb);
            end
        end
        total++;
        if (nout !== NOUT) begin
            bad++;
            $display("FAIL out_count got=%0d want=%0d", nout, NOUT);
        end
        total++;
        if (nfd !== 1) begin
            bad++;
            $display("FAIL frame_done_count got=%0d want=1", nfd);
        end
        total++;
        if (sbq.size() !== 0) begin
            bad++;
            $display("FAIL missing_outputs got=%0d want=0", sbq.size());
        end
        total++;
        if (busya !== 1'b0 || busyb !== 1'b0) begin
            bad++;
            $display("FAIL busy_end got=%b%b want=00", busya, busyb);
        end
        sbq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({va, vb, busya, busyb, fda, fdb} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000", {va, vb, busya, busyb, fda, fdb});
        end
        total++;
        if ({da, xa, ya, db, xb, yb} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got d=%0d x=%0d y=%0d want 0", da, xa, ya);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_default_flat();
        bank_sel = 2'd0;
        bypass = 1'b0;
        run_frame(0, 0, 0, -1);
    endtask

    task automatic test_laplacian();
        int lap[9] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
        load_bank(1, lap);
        write_coef(1, 9, 77);
        write_coef(1, 15, -90);
        bank_sel = 2'd1;
        run_frame(1, 0, 0, -1);
    endtask

    task automatic test_saturation();
        int hi[9] = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
        int lo[9] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
        load_bank(2, hi);
        load_bank(3, lo);
        bank_sel = 2'd2;
        run_frame(2, 0, 0, -1);
        bank_sel = 2'd3;
        run_frame(2, 0, 0, -1);
    endtask

    task automatic test_gaps();
        bank_sel = 2'd0;
        run_frame(3, 0, 0, -1);
        run_frame(3, 1, 0, -1);
    endtask

    task automatic test_bank_switch();
        bank_sel = 2'd1;
        bypass = 1'b0;
        run_frame(4, 0, 1, -1);
        run_frame(3, 1, 0, -1);
        bypass = 1'b0;
    endtask

    task automatic test_reset_abort();
        int lap[9] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
        load_bank(0, lap);
        bank_sel = 2'd0;
        bypass = 1'b0;
        run_frame(0, 0, 0, 3 * COLS + 4);
        run_frame(0, 0, 0, -1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_flat();
        test_laplacian();
        test_saturation();
        test_gaps();
        test_bank_switch();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream_filter.md
Name: conv3x3_stream_filter

Overview:
- Streaming 3x3 convolution engine for raster pixel streams.
- Successor to the fixed-weight filter wrapper. Coefficients are runtime-programmable in NUM_BANKS banks, signed and parameter-width.
- Adds per-frame bank/bypass latching, output saturation and frame-level control (busy/frame_done).
- Sits between the pixel source (camera/DMA) and the downstream image pipeline. Owns its own line buffers, window and MAC pipeline.

Parameters:
BITWIDTH, 8, pixel width (unsigned)
COEF_W, 8, coefficient width (signed two's complement)
COLS, 640, frame width in pixels (>=3)
ROWS, 480, frame height in pixels (>=3)
NUM_BANKS, 4, number of coefficient banks (>=1)
NORM_SHIFT, 8, arithmetic right shift applied to the MAC sum

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-low reset
data_in_valid  in  1  pixel beat valid; no back-pressure, the block always accepts
data_in  in  BITWIDTH  pixel, raster order, row-major
bank_sel  in  clog2(NUM_BANKS) (min 1)  coefficient bank for next frame
bypass  in  1  1 = output centre pixel unfiltered for next frame
coef_we  in  1  coefficient write strobe
coef_bank  in  clog2(NUM_BANKS) (min 1)  bank written
coef_idx  in  4  tap index 0..8, row-major (0 = top-left)
coef_data  in  COEF_W  signed coefficient
data_out_valid  out  1  output pixel valid
data_out  out  BITWIDTH  filtered pixel
x  out  clog2(COLS)+1  centre column of data_out
y  out  clog2(ROWS)+1  centre row of data_out
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last output of a frame

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; input col/row counters=0; all pipeline valids=0.
  - data_out_valid=0, data_out=0, x=0, y=0, busy=0, frame_done=0.
  - Every bank reloads the default Gaussian taps 16,32,16,32,64,32,16,32,16.
  - Line-buffer RAM contents are not reset; stale data never reaches the output (see window rule).
  - Reset mid-frame aborts the frame. No further outputs or frame_done for it. The next accepted beat is pixel (0,0).
- Coefficient writes:
  - Accepted on any cycle with coef_we=1, in any state.
  - Ignored when coef_idx>8 or coef_bank>=NUM_BANKS.
  - A write to the latched active bank during RUN takes effect on the next cycle's MAC (no shadowing). Software must not do this.
- State machine:
  - IDLE -> RUN on the first accepted beat. That beat is pixel (0,0). bank_sel and bypass are latched on the same edge and held for the whole frame.
  - RUN -> DRAIN on acceptance of pixel (COLS-1,ROWS-1).
  - DRAIN -> IDLE after 3 cycles (pipeline empty), asserting frame_done for exactly one cycle on entry to IDLE.
  - busy=1 in RUN and DRAIN.
  - An out-of-range latched bank_sel selects bank 0.
- Input:
  - Two line buffers of COLS entries and a 3x3 shift window, all advanced only on accepted beats.
  - data_in_valid=0 stalls the window; pipeline stages downstream continue to drain.
  - Beats arriving in DRAIN are ignored.
- Window rule: a window is valid when the accepted pixel has col>=2 and row>=2. Its centre is (col-1,row-1). Output frame = (COLS-2)x(ROWS-2) pixels; borders are not emitted.
- Arithmetic:
  - Each product is pixel (zero-extended) x signed coef.
  - Sum is 9 products at full width: BITWIDTH+COEF_W+5 bits signed.
  - Result = sum >>> NORM_SHIFT (arithmetic), then saturate to [0, 2^BITWIDTH-1].
  - Bypass: result = centre pixel.
- Pipeline:
  - Stage 1 registers the products; stage 2 registers the adder-tree sum; stage 3 registers shift/saturate, x and y.
  - data_out_valid rises exactly 3 clk edges after the accepting edge of the beat that completed the window.
  - data_out, x and y hold their values when data_out_valid=0.
- Counters: col wraps COLS-1 -> 0 and increments row. Row wrap at frame end returns the counters to 0 and state to DRAIN.
- Back-to-back frames: a beat accepted during DRAIN is dropped. The source must leave a gap of at least 3 cycles between frames; the first beat after IDLE is re-entered starts the new frame.

Test Plan:
1. COLS=8, ROWS=6, default bank, constant pixel 100, continuous valid -> exactly 24 outputs, all data_out=100; first (x,y)=(1,1), last=(6,4); first data_out_valid 3 cycles after accepting pixel (2,2); frame_done single pulse 3 cycles after last input.
2. Load bank 1 with Laplacian 0,-1,0,-1,4,-1,0,-1,0 and NORM_SHIFT=0; frame with flat 50 plus a single 200 at (3,3) -> output 0 everywhere except (3,3)=255 (600 saturated) and its 4-neighbours=0 (-150 clamped).
3. Bank with all taps 127, all pixels 255 -> every output 255 (saturation high); all taps -1 -> every output 0.
4. Random data_in_valid gaps (~50% duty) on a ramp image -> output sequence and values identical to the continuous run; no output while the window is not advancing.
5. Toggle bank_sel and bypass mid-frame -> no effect until the next frame. Next frame with bypass=1 -> data_out equals the centre pixel at each (x,y).
6. Assert rst=0 for one cycle at pixel (4,3) of frame 1 -> all outputs 0 next cycle, no frame_done, taps back to Gaussian. A fresh full frame then produces the 24 correct outputs.
